reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_sb_if.sv | 32 +++
 rtl/reg_scoreboard.sv | 50 +++++
 rtl/reg_file_sb.sv | 59 +++++
 tb/tb_reg_file_sb.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and the register-address type for the register file,
// its scoreboard and the decoder.
package reg_file_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int NRD_D    = 2;

  typedef logic [ADDR_W_D-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write, reservation and status signals of the register file.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int NRD    = NRD_D
);
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  we0;
  logic [ADDR_W-1:0]     waddr0;
  logic [DATA_W-1:0]     wdata0;
  logic                  we1;
  logic [ADDR_W-1:0]     waddr1;
  logic [DATA_W-1:0]     wdata1;
  logic                  rsv_valid;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  rsv_ready;
  logic [ADDR_W:0]       busy_cnt;
  logic                  wr_collide;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, rsv_valid, rsv_addr,
    input  rdata, rbusy, rsv_ready, busy_cnt, wr_collide
  );
  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, rsv_valid, rsv_addr,
    output rdata, rbusy, rsv_ready, busy_cnt, wr_collide
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: busy bits, reservation acceptance and an
// incrementally maintained count of busy registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr0,
  input  logic [ADDR_W-1:0]     clr_addr0,
  input  logic                  clr1,
  input  logic [ADDR_W-1:0]     clr_addr1,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ready,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       busy_cnt
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] clr_vec, set_vec;
  logic             set_en, inc, dec0, dec1;

  always_comb begin
    clr_vec = '0;
    if (clr0) clr_vec[clr_addr0] = 1'b1;
    if (clr1) clr_vec[clr_addr1] = 1'b1;
    rsv_ready = (rsv_addr == '0) || !busy[rsv_addr] || clr_vec[rsv_addr];
    set_en    = rsv_valid && rsv_ready && (rsv_addr != '0);
    set_vec   = '0;
    if (set_en) set_vec[rsv_addr] = 1'b1;
    // Count only real transitions: a set over a same-cycle clear keeps the bit
    // at 1, and two writes to one address clear it once.
    inc  = set_en && !busy[rsv_addr];
    dec0 = clr0 && busy[clr_addr0] && !set_vec[clr_addr0];
    dec1 = clr1 && busy[clr_addr1] && !set_vec[clr_addr1] &&
           !(clr0 && (clr_addr0 == clr_addr1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~clr_vec) | set_vec;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass, dual-write collision flag and a
// reservation scoreboard; register 0 is hardwired to zero.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int NRD    = NRD_D
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;
  logic                         wr0, wr1, collide;

  assign wr0     = bus.we0 && (bus.waddr0 != '0);
  assign wr1     = bus.we1 && (bus.waddr1 != '0);
  assign collide = wr0 && wr1 && (bus.waddr0 == bus.waddr1);

  // Port 1 is written last so it wins on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= '0;
      bus.wr_collide <= 1'b0;
    end else begin
      if (wr0 && !collide) regs[bus.waddr0] <= bus.wdata0;
      if (wr1)             regs[bus.waddr1] <= bus.wdata1;
      bus.wr_collide <= collide;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];
    assign bus.rdata[k*DATA_W +: DATA_W] =
      (ra == '0)                    ? '0 :
      (wr1 && bus.waddr1 == ra)     ? bus.wdata1 :
      (wr0 && bus.waddr0 == ra)     ? bus.wdata0 : regs[ra];
    assign bus.rbusy[k] = (ra != '0) && busy[ra];
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr0      (wr0),
    .clr_addr0 (bus.waddr0),
    .clr1      (wr1),
    .clr_addr1 (bus.waddr1),
    .rsv_valid (bus.rsv_valid),
    .rsv_addr  (bus.rsv_addr),
    .rsv_ready (bus.rsv_ready),
    .busy      (busy),
    .busy_cnt  (bus.busy_cnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb plus hand sequences for
// collision timing and asynchronous reset.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       we0; reg_addr_t wa0; logic [31:0] wd0;
    logic       we1; reg_addr_t wa1; logic [31:0] wd1;
    logic       rv;  reg_addr_t ra;
    reg_addr_t  rd0; reg_addr_t rd1;
    logic [31:0] e0; logic [31:0] e1;
    logic [1:0] eb;  logic erdy; logic [5:0] ecnt; logic ecol;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we0, input reg_addr_t wa0, input logic [31:0] wd0,
                     input logic we1, input reg_addr_t wa1, input logic [31:0] wd1,
                     input logic rv, input reg_addr_t ra,
                     input reg_addr_t rd0, input reg_addr_t rd1,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
                     input logic erdy, input logic [5:0] ecnt, input logic ecol);
    vec_t v;
    v = '{we0, wa0, wd0, we1, wa1, wd1, rv, ra, rd0, rd1, e0, e1, eb, erdy, ecnt, ecol};
    vq.push_back(v);
  endtask

  task automatic drive(input logic we0, input reg_addr_t wa0, input logic [31:0] wd0,
                       input logic we1, input reg_addr_t wa1, input logic [31:0] wd1,
                       input logic rv, input reg_addr_t ra,
                       input reg_addr_t rd0, input reg_addr_t rd1);
    bus.we0 = we0; bus.waddr0 = wa0; bus.wdata0 = wd0;
    bus.we1 = we1; bus.waddr1 = wa1; bus.wdata1 = wd1;
    bus.rsv_valid = rv; bus.rsv_addr = ra;
    bus.raddr = {rd1, rd0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy_cnt", 64'(bus.busy_cnt), 0);
    chk("reset wr_collide", 64'(bus.wr_collide), 0);
    chk("reset rdata", 64'(bus.rdata), 0);
    chk("reset rbusy", 64'(bus.rbusy), 0);
    rst_n = 1'b1;

    //   we0 wa0 wd0           we1 wa1 wd1    rv ra  rd0 rd1  e0            e1            eb    rdy cnt col
    add(0, 0, 0,               0, 0, 0,       0, 0,  0, 5,    0,            0,            2'b00, 1, 0, 0);
    add(1, 5, 32'hDEADBEEF,    0, 0, 0,       0, 0,  5, 0,    32'hDEADBEEF, 0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       0, 0,  5, 0,    32'hDEADBEEF, 0,            2'b00, 1, 0, 0);
    add(1, 0, 32'h1,           0, 0, 0,       0, 0,  0, 5,    0,            32'hDEADBEEF, 2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       0, 0,  0, 5,    0,            32'hDEADBEEF, 2'b00, 1, 0, 0);
    add(1, 7, 32'h11,          1, 7, 32'h22,  0, 0,  7, 5,    32'h22,       32'hDEADBEEF, 2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       0, 0,  7, 7,    32'h22,       32'h22,       2'b00, 1, 0, 1);
    add(0, 0, 0,               0, 0, 0,       0, 0,  7, 0,    32'h22,       0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       1, 3,  3, 0,    0,            0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       1, 3,  3, 0,    0,            0,            2'b01, 0, 1, 0);
    add(0, 0, 0,               1, 3, 32'h33,  0, 3,  3, 3,    32'h33,       32'h33,       2'b11, 1, 1, 0);
    add(0, 0, 0,               0, 0, 0,       0, 3,  3, 0,    32'h33,       0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       1, 4,  4, 0,    0,            0,            2'b00, 1, 0, 0);
    add(1, 4, 32'h44,          0, 0, 0,       1, 4,  4, 0,    32'h44,       0,            2'b01, 1, 1, 0);
    add(0, 0, 0,               0, 0, 0,       0, 4,  4, 0,    32'h44,       0,            2'b01, 0, 1, 0);
    add(0, 0, 0,               1, 4, 32'h45,  0, 0,  4, 0,    32'h45,       0,            2'b01, 1, 1, 0);
    add(0, 0, 0,               0, 0, 0,       1, 1,  4, 1,    32'h45,       0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       1, 2,  1, 2,    0,            0,            2'b01, 1, 1, 0);
    add(1, 1, 32'hA1,          1, 2, 32'hB2,  0, 0,  1, 2,    32'hA1,       32'hB2,       2'b11, 1, 2, 0);
    add(0, 0, 0,               0, 0, 0,       0, 0,  1, 2,    32'hA1,       32'hB2,       2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       1, 0,  0, 0,    0,            0,            2'b00, 1, 0, 0);
    add(0, 0, 0,               0, 0, 0,       0, 0,  0, 5,    0,            32'hDEADBEEF, 2'b00, 1, 0, 0);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].we0, vq[i].wa0, vq[i].wd0, vq[i].we1, vq[i].wa1, vq[i].wd1,
            vq[i].rv, vq[i].ra, vq[i].rd0, vq[i].rd1);
      #1;
      chk($sformatf("v%0d rdata0", i), 64'(bus.rdata[31:0]), 64'(vq[i].e0));
      chk($sformatf("v%0d rdata1", i), 64'(bus.rdata[63:32]), 64'(vq[i].e1));
      chk($sformatf("v%0d rbusy", i), 64'(bus.rbusy), 64'(vq[i].eb));
      chk($sformatf("v%0d rsv_ready", i), 64'(bus.rsv_ready), 64'(vq[i].erdy));
      chk($sformatf("v%0d busy_cnt", i), 64'(bus.busy_cnt), 64'(vq[i].ecnt));
      chk($sformatf("v%0d wr_collide", i), 64'(bus.wr_collide), 64'(vq[i].ecol));
    end

    // Three reservations, then reset asserted mid-cycle.
    for (int a = 1; a <= 3; a++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 1, 5'(a), 5, 7);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    #1;
    chk("pre-reset busy_cnt", 64'(bus.busy_cnt), 3);
    chk("pre-reset r5", 64'(bus.rdata[31:0]), 64'h0DEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async reset busy_cnt", 64'(bus.busy_cnt), 0);
    chk("async reset rdata", 64'(bus.rdata), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    chk("async reset rbusy", 64'(bus.rbusy), 0);

    // Activity coincident with reset is lost.
    drive(1, 8, 32'h77, 0, 0, 0, 1, 6, 8, 6);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 6);
    #1;
    chk("in-reset write lost", 64'(bus.rdata[31:0]), 0);
    chk("in-reset rsv lost", 64'(bus.busy_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 6, 8, 6);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 6);
    #1;
    chk("first rsv after reset", 64'(bus.busy_cnt), 1);
    chk("first rsv rbusy", 64'(bus.rbusy), 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
